// File: rtl/uart_tx_frame_if.sv
// Host-side byte handshake and serial line of the UART transmitter.
interface uart_tx_frame_if;
    logic [7:0] DIN;
    logic       DIN_VLD;
    logic       DIN_RDY;
    logic       UART_TXD;
    logic       BUSY;

    modport master (output DIN, DIN_VLD, input DIN_RDY, UART_TXD, BUSY);
    modport slave  (input DIN, DIN_VLD, output DIN_RDY, UART_TXD, BUSY);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Latency: start bit on UART_TXD the cycle after the accept edge; frame is (9+P+STOP_BITS)*CLK_DIV_VAL cycles.
// Backpressure: DIN_RDY is low for the whole frame; DIN_VLD is ignored while DIN_RDY is low.
module uart_tx_frame #(
    parameter int CLK_DIV_VAL = 16,
    parameter     PARITY_BIT  = "none",
    parameter int STOP_BITS   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_frame_if.slave   host
);

    localparam logic [63:0] PSTR = 64'(PARITY_BIT);
    localparam int PAR_MODE = (PSTR == 64'("none"))  ? 0 :
                              (PSTR == 64'("even"))  ? 1 :
                              (PSTR == 64'("odd"))   ? 2 :
                              (PSTR == 64'("mark"))  ? 3 :
                              (PSTR == 64'("space")) ? 4 : -1;
    localparam int CW = (CLK_DIV_VAL > 2) ? $clog2(CLK_DIV_VAL) : 1;

    generate
        if (CLK_DIV_VAL < 2 || (STOP_BITS != 1 && STOP_BITS != 2) || PAR_MODE < 0) begin : g_param_err
            $error("uart_tx_frame: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, STARTBIT, DATABITS, PARITYBIT, STOPBIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic          stop_idx, stop_idx_n;
    logic [7:0]    shift, shift_n;
    logic          par, par_n;
    logic          txd, txd_n;
    logic          rdy, rdy_n;
    logic          busy, busy_n;

    logic          tick;
    logic          last_stop;
    logic          par_calc;
    logic [2:0]    idx_p1;

    assign tick      = (cnt == CW'(CLK_DIV_VAL - 1));
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
    assign idx_p1    = idx + 3'd1;

    always_comb begin
        case (PAR_MODE)
            1:       par_calc = ^host.DIN;
            2:       par_calc = ~^host.DIN;
            3:       par_calc = 1'b1;
            default: par_calc = 1'b0;
        endcase
    end

    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        idx_n      = idx;
        stop_idx_n = stop_idx;
        shift_n    = shift;
        par_n      = par;
        txd_n      = txd;
        rdy_n      = rdy;
        busy_n     = busy;

        if (state != IDLE) begin
            cnt_n = tick ? '0 : cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                // DIN_RDY first rises here on the edge after reset is released
                txd_n  = 1'b1;
                rdy_n  = 1'b1;
                busy_n = 1'b0;
                if (rdy && host.DIN_VLD) begin
                    state_n    = STARTBIT;
                    shift_n    = host.DIN;
                    par_n      = par_calc;
                    txd_n      = 1'b0;
                    rdy_n      = 1'b0;
                    busy_n     = 1'b1;
                    cnt_n      = '0;
                    idx_n      = '0;
                    stop_idx_n = 1'b0;
                end
            end
            STARTBIT: begin
                if (tick) begin
                    state_n = DATABITS;
                    idx_n   = '0;
                    txd_n   = shift[0];
                end
            end
            DATABITS: begin
                if (tick) begin
                    if (idx == 3'd7) begin
                        if (PAR_MODE == 0) begin
                            state_n    = STOPBIT;
                            stop_idx_n = 1'b0;
                            txd_n      = 1'b1;
                        end else begin
                            state_n = PARITYBIT;
                            txd_n   = par;
                        end
                    end else begin
                        idx_n = idx_p1;
                        txd_n = shift[idx_p1];
                    end
                end
            end
            PARITYBIT: begin
                if (tick) begin
                    state_n    = STOPBIT;
                    stop_idx_n = 1'b0;
                    txd_n      = 1'b1;
                end
            end
            STOPBIT: begin
                if (tick) begin
                    if (last_stop) begin
                        state_n = IDLE;
                        rdy_n   = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
                rdy_n   = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par      <= 1'b0;
            txd      <= 1'b1;
            rdy      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            stop_idx <= stop_idx_n;
            shift    <= shift_n;
            par      <= par_n;
            txd      <= txd_n;
            rdy      <= rdy_n;
            busy     <= busy_n;
        end
    end

    assign host.UART_TXD = txd;
    assign host.DIN_RDY  = rdy;
    assign host.BUSY     = busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: six instances at CLK_DIV_VAL=4 covering each parity mode and 2 stop bits.
module tb_uart_tx_frame;

    logic clk;
    logic rst;
    logic [7:0] din [6];
    logic [5:0] vld;
    wire  [5:0] txd;
    wire  [5:0] rdy;
    wire  [5:0] bsy;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: none/1 stop  1: even  2: odd  3: mark  4: space  5: none/2 stops
    uart_tx_frame_if if0 ();
    uart_tx_frame_if if1 ();
    uart_tx_frame_if if2 ();
    uart_tx_frame_if if3 ();
    uart_tx_frame_if if4 ();
    uart_tx_frame_if if5 ();

    uart_tx_frame #(.CLK_DIV_VAL(4), .PARITY_BIT("none"),  .STOP_BITS(1)) u0 (.CLK(clk), .RST(rst), .host(if0.slave));
    uart_tx_frame #(.CLK_DIV_VAL(4), .PARITY_BIT("even"),  .STOP_BITS(1)) u1 (.CLK(clk), .RST(rst), .host(if1.slave));
    uart_tx_frame #(.CLK_DIV_VAL(4), .PARITY_BIT("odd"),   .STOP_BITS(1)) u2 (.CLK(clk), .RST(rst), .host(if2.slave));
    uart_tx_frame #(.CLK_DIV_VAL(4), .PARITY_BIT("mark"),  .STOP_BITS(1)) u3 (.CLK(clk), .RST(rst), .host(if3.slave));
    uart_tx_frame #(.CLK_DIV_VAL(4), .PARITY_BIT("space"), .STOP_BITS(1)) u4 (.CLK(clk), .RST(rst), .host(if4.slave));
    uart_tx_frame #(.CLK_DIV_VAL(4), .PARITY_BIT("none"),  .STOP_BITS(2)) u5 (.CLK(clk), .RST(rst), .host(if5.slave));

    assign if0.DIN = din[0];  assign if0.DIN_VLD = vld[0];
    assign if1.DIN = din[1];  assign if1.DIN_VLD = vld[1];
    assign if2.DIN = din[2];  assign if2.DIN_VLD = vld[2];
    assign if3.DIN = din[3];  assign if3.DIN_VLD = vld[3];
    assign if4.DIN = din[4];  assign if4.DIN_VLD = vld[4];
    assign if5.DIN = din[5];  assign if5.DIN_VLD = vld[5];

    assign txd = {if5.UART_TXD, if4.UART_TXD, if3.UART_TXD, if2.UART_TXD, if1.UART_TXD, if0.UART_TXD};
    assign rdy = {if5.DIN_RDY,  if4.DIN_RDY,  if3.DIN_RDY,  if2.DIN_RDY,  if1.DIN_RDY,  if0.DIN_RDY};
    assign bsy = {if5.BUSY,     if4.BUSY,     if3.BUSY,     if2.BUSY,     if1.BUSY,     if0.BUSY};

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected line level per cycle, cycle 0 being the first start-bit cycle; par<0 means no parity bit.
    function automatic logic [63:0] frame_wave(input logic [7:0] d, input int par, input int ncyc);
        logic [63:0] w;
        int b;
        w = '0;
        for (int c = 0; c < ncyc; c++) begin
            b = c / 4;
            if (b == 0)                 w[c] = 1'b0;
            else if (b <= 8)            w[c] = d[b-1];
            else if (b == 9 && par >= 0) w[c] = par[0];
            else                        w[c] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [63:0] ones(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i < hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic wait_rdy(input int k);
        int n;
        n = 0;
        while (rdy[k] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("rdy_timeout", 64'(rdy[k]), 64'd1);
    endtask

    // Leaves the bench at the negedge right after the accept edge (first start-bit cycle).
    task automatic start(input int k, input logic [7:0] d, input bit hold);
        wait_rdy(k);
        din[k] = d;
        vld[k] = 1'b1;
        step();
        if (!hold) vld[k] = 1'b0;
    endtask

    task automatic capture(input int k, input int ncyc, input int pc, input logic [7:0] pd,
                           output logic [63:0] wv, output logic [63:0] rv, output logic [63:0] bv);
        wv = '0; rv = '0; bv = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (pc >= 0 && c == pc) begin
                din[k] = pd;
                vld[k] = 1'b1;
            end else if (pc >= 0 && c == pc + 1) begin
                vld[k] = 1'b0;
            end
            wv[c] = txd[k];
            rv[c] = rdy[k];
            bv[c] = bsy[k];
            step();
        end
    endtask

    logic [63:0] wv, rv, bv;
    logic [7:0]  rxb, tb_byte;
    logic        rx_start, rx_par, rx_stop;
    logic [7:0]  pbytes [4];
    int          pexp   [4];

    initial begin
        rst = 1'b1;
        vld = '0;
        for (int i = 0; i < 6; i++) din[i] = 8'h00;
        step(); step(); step();

        chk("reset_txd",  64'(txd), 64'h3F);
        chk("reset_rdy",  64'(rdy), 64'h00);
        chk("reset_busy", 64'(bsy), 64'h00);
        rst = 1'b0;
        step();
        chk("rdy_after_release", 64'(rdy), 64'h3F);

        // 0x55, no parity, 1 stop: alternating levels, ready again 40 cycles after start
        start(0, 8'h55, 1'b0);
        capture(0, 44, -1, 8'h00, wv, rv, bv);
        chk("t1_wave", wv, frame_wave(8'h55, -1, 44));
        chk("t1_rdy",  rv, ones(40, 44));
        chk("t1_busy", bv, ones(0, 40));

        // parity modes: even/odd on 0x03, mark/space on 0x00
        pbytes[0] = 8'h03; pexp[0] = 0;
        pbytes[1] = 8'h03; pexp[1] = 1;
        pbytes[2] = 8'h00; pexp[2] = 1;
        pbytes[3] = 8'h00; pexp[3] = 0;
        for (int k = 1; k <= 4; k++) begin
            start(k, pbytes[k-1], 1'b0);
            capture(k, 48, -1, 8'h00, wv, rv, bv);
            chk($sformatf("t2_wave_%0d", k), wv, frame_wave(pbytes[k-1], pexp[k-1], 48));
            chk($sformatf("t2_rdy_%0d", k),  rv, ones(44, 48));
        end

        // two stop bits, DIN_VLD held: second start exactly 45 cycles after the first
        start(5, 8'hA5, 1'b1);
        din[5] = 8'h3C;
        capture(5, 45, -1, 8'h00, wv, rv, bv);
        chk("t3_wave1", wv, frame_wave(8'hA5, -1, 45));
        chk("t3_rdy1",  rv, ones(44, 45));
        vld[5] = 1'b0;
        capture(5, 48, -1, 8'h00, wv, rv, bv);
        chk("t3_wave2", wv, frame_wave(8'h3C, -1, 48));
        chk("t3_rdy2",  rv, ones(44, 48));

        // DIN_VLD pulse with 0xFF mid-frame is ignored
        start(0, 8'h00, 1'b0);
        capture(0, 52, 10, 8'hFF, wv, rv, bv);
        chk("t4_wave", wv, frame_wave(8'h00, -1, 52));
        chk("t4_rdy",  rv, ones(40, 52));

        // reset during data bit 3 of 0xF0 (line low there)
        start(0, 8'hF0, 1'b0);
        for (int c = 0; c < 17; c++) step();
        chk("t5_pre_txd", 64'(txd[0]), 64'd0);
        rst = 1'b1;
        step();
        chk("t5_rst_txd",  64'(txd[0]), 64'd1);
        chk("t5_rst_busy", 64'(bsy[0]), 64'd0);
        chk("t5_rst_rdy",  64'(rdy[0]), 64'd0);
        rst = 1'b0;
        step();
        chk("t5_rdy_release", 64'(rdy[0]), 64'd1);
        start(0, 8'h81, 1'b0);
        capture(0, 44, -1, 8'h00, wv, rv, bv);
        chk("t5_wave", wv, frame_wave(8'h81, -1, 44));

        // receiver model on the even-parity instance, sampling mid-bit
        for (int i = 0; i < 256; i++) begin
            tb_byte = 8'($urandom_range(0, 255));
            wait_rdy(1);
            din[1] = tb_byte;
            vld[1] = 1'b1;
            step();
            vld[1] = 1'b0;
            for (int n = 0; n < 8 && txd[1] !== 1'b0; n++) step();
            step(); step();
            rx_start = txd[1];
            for (int j = 0; j < 8; j++) begin
                step(); step(); step(); step();
                rxb[j] = txd[1];
            end
            step(); step(); step(); step();
            rx_par = txd[1];
            step(); step(); step(); step();
            rx_stop = txd[1];
            chk($sformatf("t6_rx_%0d", i), {53'd0, rx_start, rx_stop, rx_par, rxb},
                {53'd0, 1'b0, 1'b1, ^tb_byte, tb_byte});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
